uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Asynchronous serial receiver, 8N1, LSB first. It is the receive-side partner of UART_TX.
//   - Samples the serial line, rebuilds each byte, and presents it with a one-cycle valid strobe.
//   - Sits between the board RX pin and the byte-consumer logic.
//   - Also serves as the loopback checker for UART_TX in the system bench.
// PARAMETERS
//   CLK_FREQ      12000000  system clock frequency in Hz
//   BAUD_RATE     9600      line rate in bit/s
//   CLKS_PER_BIT  CLK_FREQ/BAUD_RATE (=1250)  clocks per bit; integer division; must be 2..65535
//   HALF_BIT      CLKS_PER_BIT/2 (=625)      start-bit qualification point
// PORTS
//   clock      in   1  system clock; all logic on the rising edge
//   reset      in   1  synchronous, active-high reset
//   rx         in   1  asynchronous serial input; idles high
//   data_out   out  8  last correctly framed byte; holds its value until the next good frame
//   valid      out  1  one-cycle pulse: data_out has just been updated
//   frame_err  out  1  one-cycle pulse: stop bit sampled low; data_out not updated
//   busy       out  1  high while a frame is being received (state != IDLE)
// BEHAVIOUR
//   Reset values
//   - data_out=8'h00, valid=0, frame_err=0, busy=0.
//   - state=IDLE, synchroniser flops=1, bit counter=0, clock counter=0.
//   Input synchroniser
//   - rx passes through 2 flops to form rx_s. All decisions use rx_s only.
//   - rx_s therefore lags the pin by 2 clocks.
//   Clock counter
//   - 16-bit; cleared on every state change.
//   - Counts up by 1 per clock otherwise.
//   State machine
//   - IDLE: if rx_s==0, go to START.
//   - START: when cnt==HALF_BIT-1, sample rx_s.
//     * 0: go to DATA with bit_idx=0.
//     * 1: glitch; return to IDLE with no strobe.
//   - DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into shreg[7] (right shift, LSB first).
//     * Then bit_idx++.
//     * After the 8th sample (bit_idx==7), go to STOP.
//   - STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
//     * 1: data_out<=shreg, valid=1 for 1 clock, go to IDLE.
//     * 0: frame_err=1 for 1 clock, go to BREAK.
//   - BREAK: wait until rx_s==1, then go to IDLE.
//     * A line held low never retriggers reception.
//   Timing
//   - Let t0 be the clock where rx_s first reads 0 in IDLE.
//   - Data bit n is sampled at t0 + HALF_BIT + (n+1)*CLKS_PER_BIT, nominally mid-bit.
//   - valid/frame_err are asserted in the clock after the stop sample, at t0 + HALF_BIT + 9*CLKS_PER_BIT + 1.
//   - Latency from the pin edge adds the 2 synchroniser clocks.
//   busy
//   - Combinational decode of state != IDLE.
//   - Deasserts in the same clock that valid (or, after BREAK, the return to IDLE) occurs.
//   Back-to-back frames
//   - IDLE is re-entered mid-stop-bit, so a start edge right after the stop bit is caught.
//   - No idle gap is required.
//   Outputs
//   - valid and frame_err are never high together.
//   - No overrun detection: the consumer must take data_out within one frame time.
//   Reset mid-frame
//   - Reset aborts immediately to the reset values; the partial byte is discarded.
//   - After reset, a frame already in progress is resynchronised only on the next falling edge seen from IDLE.
// TESTING
//   1 Loopback: UART_TX -> rx; send 0x55, 0xAA, 0xFF, 0x00, 0x41 -> five valid pulses with matching data_out and no frame_err.
//   2 Timing: drive rx low at T, then frame 0xA5 -> valid exactly 2+HALF_BIT+9*CLKS_PER_BIT+1 clocks after T (11878 @ defaults).
//   3 Glitch: rx low for 300 clocks, then high -> busy pulses, returns to 0 by clock ~627; no valid or frame_err.
//   4 Framing error: frame 0x3C with stop bit low, rx held low 3 bit-times -> one frame_err pulse.
//     * No valid; data_out keeps its previous value.
//     * busy stays high until rx returns high.
//     * A following good 0x3C is received.
//   5 Back-to-back: two frames 0x12, 0x34 with zero idle gap -> two valid pulses spaced 10*CLKS_PER_BIT apart.
//   6 Reset mid-frame: assert reset for 1 clock during bit 4 of 0x81.
//     * Next clock: busy=0, valid=0, data_out=0x00.
//     * The next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first. Start bit qualified at half a bit, data and
// stop bits sampled mid-bit; good frames update o_data_out with a one-cycle strobe.
module uart_rx #(
  parameter  int CLK_FREQ     = 12000000,
  parameter  int BAUD_RATE    = 9600,
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  localparam int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data_out,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [15:0] LP_BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF_END = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      r_state;
  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shreg;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;
  logic        w_rx_s;

  assign w_rx_s = r_sync[1];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_sync    <= 2'b11;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shreg   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_cnt   <= r_cnt + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= 16'd0;
          end
        end
        S_START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (r_cnt == LP_HALF_END) begin
            r_cnt <= 16'd0;
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (r_cnt == LP_BIT_END) begin
            r_cnt     <= 16'd0;
            r_shreg   <= {w_rx_s, r_shreg[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (r_cnt == LP_BIT_END) begin
            r_cnt <= 16'd0;
            if (w_rx_s) begin
              r_data  <= r_shreg;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 16'd0;
        end
      endcase
    end
  end

  assign o_data_out  = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced bit time (16 clocks/bit, half-bit 8).
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int HALF    = 8;
  localparam int LATENCY = 155;  // 2 + 8 + 9*16 + 1

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_both  = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;

  uart_rx #(.CLK_FREQ(1600), .BAUD_RATE(100)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_rx       (rx),
    .o_data_out (data_out),
    .o_valid    (valid),
    .o_frame_err(frame_err),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid        <= n_valid + 1;
      prev_valid_cyc <= last_valid_cyc;
      last_valid_cyc <= cyc;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (valid && frame_err) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, then the given stop level (left on the line).
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  logic [7:0] lb_tab [5] = '{8'h55, 8'hAA, 8'hFF, 8'h00, 8'h41};

  initial begin
    int v0, f0, t0;
    logic [7:0] rd;
    rx  = 1'b1;
    rst = 1'b1;
    tick(3);
    chk("rst_data",  {24'd0, data_out}, 32'h00);
    chk("rst_valid", {31'd0, valid},     32'd0);
    chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    rst = 1'b0;
    tick(2 * CPB);

    // Loopback bytes
    for (int k = 0; k < 5; k++) begin
      v0 = n_valid; f0 = n_ferr;
      send_frame(lb_tab[k], 1'b1);
      rx = 1'b1;
      tick(CPB);
      chk($sformatf("lb_data%0d", k),  {24'd0, data_out}, {24'd0, lb_tab[k]});
      chk($sformatf("lb_vcnt%0d", k),  n_valid - v0, 32'd1);
      chk($sformatf("lb_fcnt%0d", k),  n_ferr - f0,  32'd0);
    end

    // Pin-to-valid latency
    tick(2 * CPB);
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    rx = 1'b1;
    tick(CPB);
    chk("lat_data", {24'd0, data_out}, 32'hA5);
    chk("lat_clks", last_valid_cyc - t0, LATENCY);

    // Short low glitch shorter than half a bit
    tick(2 * CPB);
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    tick(4);
    chk("gl_busy_hi", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    tick(10);
    chk("gl_busy_lo", {31'd0, busy}, 32'd0);
    chk("gl_vcnt", n_valid - v0, 32'd0);
    chk("gl_fcnt", n_ferr - f0,  32'd0);

    // Framing error then line held low (break)
    tick(2 * CPB);
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    tick(3 * CPB);
    chk("fe_fcnt", n_ferr - f0,  32'd1);
    chk("fe_vcnt", n_valid - v0, 32'd0);
    chk("fe_data", {24'd0, data_out}, 32'hA5);
    chk("fe_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    tick(4);
    chk("fe_idle", {31'd0, busy}, 32'd0);
    tick(2 * CPB);
    v0 = n_valid;
    send_frame(8'h3C, 1'b1);
    rx = 1'b1;
    tick(CPB);
    chk("fe_good",   {24'd0, data_out}, 32'h3C);
    chk("fe_good_v", n_valid - v0, 32'd1);

    // Back-to-back with no idle gap
    tick(2 * CPB);
    v0 = n_valid;
    send_frame(8'h12, 1'b1);
    chk("b2b_d0", {24'd0, data_out}, 32'h12);
    send_frame(8'h34, 1'b1);
    rx = 1'b1;
    tick(CPB);
    chk("b2b_d1",  {24'd0, data_out}, 32'h34);
    chk("b2b_cnt", n_valid - v0, 32'd2);
    chk("b2b_gap", last_valid_cyc - prev_valid_cyc, 10 * CPB);

    // Reset in the middle of bit 4 of 0x81
    tick(2 * CPB);
    rd = 8'h81;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = rd[i];
      tick(CPB);
    end
    rx = rd[4];
    tick(HALF);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mr_busy",  {31'd0, busy},      32'd0);
    chk("mr_valid", {31'd0, valid},     32'd0);
    chk("mr_data",  {24'd0, data_out},  32'h00);
    tick(CPB - HALF - 1);
    for (int i = 5; i < 8; i++) begin
      rx = rd[i];
      tick(CPB);
    end
    rx = 1'b1;
    tick(12 * CPB);
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h7E, 1'b1);
    rx = 1'b1;
    tick(CPB);
    chk("mr_next",   {24'd0, data_out}, 32'h7E);
    chk("mr_next_v", n_valid - v0, 32'd1);
    chk("mr_next_f", n_ferr - f0,  32'd0);

    chk("never_both", n_both, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
